hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard and stall controller for the 5-stage core. Produces the
//   write-enable / flush controls for the IF/ID and ID/EX pipeline registers
//   and the PC write enable, combining three hazard sources:
//     - load-use between the load in EX and the instruction in ID
//     - taken branch (EX) or jump (ID) redirect
//     - multi-cycle MUL/DIV busy window, tracked by a small FSM + counter
//   Also keeps a saturating count of front-end stall cycles.
//
// Ports
//   Clk, Rst           clock; synchronous active-high reset
//   id_rs, id_rt       source registers of the instruction in ID
//   id_uses_rs/_rt     ID instruction actually reads rs / rt
//   id_uses_hilo       ID instruction reads HI/LO or is itself MUL/DIV
//   id_jump            unconditional jump resolved in ID
//   ex_memread, ex_rd  EX instruction is a load, and its destination
//   ex_branch_taken    branch resolved taken in EX
//   mdu_start          MUL/DIV issued from EX this cycle
//   mdu_is_div         qualifies mdu_start: 1 = DIV, 0 = MUL
//   pc_we              PC write enable
//   ifid_we/_flush     IF/ID write enable / flush
//   idex_we/_flush     ID/EX write enable / flush (bubble insert)
//   mdu_busy           MDU operation in flight
//   stall_cycles       saturating count of front-end stall cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_W   = 5,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_uses_hilo,
   input  logic             id_jump,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mdu_start,
   input  logic             mdu_is_div,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   // The busy counter only has to hold the longest latency minus one.
   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int LAT_W   = $clog2(MAX_LAT + 1);

   localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LAT - 1);
   localparam logic [LAT_W-1:0] DIV_LOAD = LAT_W'(DIV_LAT - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_e;

   mdu_state_e       state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic load_use;
   logic mdu_stall;
   logic fe_stall;

   // -------------------------------------------------------------------------
   // Hazard detection
   // -------------------------------------------------------------------------
   // Register 0 is hard-wired to zero, so a load targeting it never creates
   // a real dependency.
   assign load_use = ex_memread && (ex_rd != '0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));

   // Reset masks busy immediately so the forced reset outputs never see a
   // stale BUSY state from before the reset edge.
   assign mdu_busy  = (state_q == BUSY) && !Rst;
   assign mdu_stall = mdu_busy && id_uses_hilo;
   assign fe_stall  = load_use || mdu_stall;

   // -------------------------------------------------------------------------
   // Pipeline controls (combinational, zero latency)
   // -------------------------------------------------------------------------
   // NOTE: every output gets a default before the priority chain, so no path
   // through this block leaves a signal unassigned and no latch is inferred.
   always_comb begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b0;
      idex_we    = 1'b1;
      idex_flush = 1'b0;

      if (Rst || ex_branch_taken) begin
         // Reset clears the downstream registers; a taken branch squashes the
         // wrong-path instructions in IF/ID and ID/EX, so any stall the ID
         // instruction would have raised is irrelevant.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (fe_stall) begin
         // Hold PC and IF/ID, push one bubble into EX per stalled cycle.
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_flush = 1'b1;
      end else if (id_jump) begin
         // Only the fetched slot behind the jump is wrong-path.
         ifid_flush = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // MDU busy FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      if (Rst) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mdu_start) begin
                  cnt_d   = mdu_is_div ? DIV_LOAD : MUL_LOAD;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               // A second mdu_start here is ignored: the op in flight is
               // committed and neither restarts nor extends. A taken branch
               // does not cancel it either.
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - LAT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Stall-cycle performance counter (saturating)
   // -------------------------------------------------------------------------
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (Rst) begin
         stall_cycles_d = '0;
      end else if (fe_stall && !ex_branch_taken && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_cycles_q;

   // -------------------------------------------------------------------------
   // State registers (reset is folded into the _d logic above)
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its pre-edge inputs, independent of statement order.
   always_ff @(posedge Clk) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Scoreboard bench for hazard_ctrl. Two instances share the same inputs:
//   one with the default 16-bit stall counter and one with a 4-bit counter to
//   exercise saturation. The stimulus process drives a vector shortly after
//   each rising edge, computes the expected response from a cycle-count model
//   (remaining busy cycles as an integer, counters as ints) and pushes it into
//   a queue; the monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int REG_W   = 5;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;

   typedef struct {
      logic             rst;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic             uses_rs;
      logic             uses_rt;
      logic             uses_hilo;
      logic             jump;
      logic             memread;
      logic [REG_W-1:0] rd;
      logic             br;
      logic             start;
      logic             is_div;
   } vec_t;

   typedef struct {
      logic [4:0]  ctl;   // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush}
      logic        busy;
      logic [15:0] s16;
      logic [3:0]  s4;
   } exp_t;

   logic             Clk = 1'b0;
   logic             Rst;
   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic             id_uses_rs, id_uses_rt, id_uses_hilo, id_jump;
   logic             ex_memread, ex_branch_taken, mdu_start, mdu_is_div;

   logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_flush_a, mdu_busy_a;
   logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_flush_b, mdu_busy_b;
   logic [15:0] stall_a;
   logic [3:0]  stall_b;

   always #5 Clk = ~Clk;

   hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(16)) dut_a (
      .Clk(Clk), .Rst(Rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_uses_hilo(id_uses_hilo), .id_jump(id_jump),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
      .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a),
      .idex_we(idex_we_a), .idex_flush(idex_flush_a), .mdu_busy(mdu_busy_a),
      .stall_cycles(stall_a)
   );

   hazard_ctrl #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut_b (
      .Clk(Clk), .Rst(Rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_uses_hilo(id_uses_hilo), .id_jump(id_jump),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
      .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
      .idex_we(idex_we_b), .idex_flush(idex_flush_b), .mdu_busy(mdu_busy_b),
      .stall_cycles(stall_b)
   );

   // -------------------------------------------------------------------------
   // Scoreboard + counters
   // -------------------------------------------------------------------------
   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   n_checks    = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (vector %0d, t=%0t)",
                  name, act, exp_v, vectors, $time);
      end
   endtask

   exp_t mon_e;
   always @(negedge Clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         vectors++;
         check("ctl_a",  {11'd0, pc_we_a, ifid_we_a, ifid_flush_a, idex_we_a, idex_flush_a},
               {11'd0, mon_e.ctl});
         check("ctl_b",  {11'd0, pc_we_b, ifid_we_b, ifid_flush_b, idex_we_b, idex_flush_b},
               {11'd0, mon_e.ctl});
         check("busy_a", {15'd0, mdu_busy_a}, {15'd0, mon_e.busy});
         check("busy_b", {15'd0, mdu_busy_b}, {15'd0, mon_e.busy});
         check("stall16", stall_a, mon_e.s16);
         check("stall4",  {12'd0, stall_b}, {12'd0, mon_e.s4});
      end
   end

   // -------------------------------------------------------------------------
   // Reference model: state after the most recent rising edge
   // -------------------------------------------------------------------------
   int busy_rem = 0;   // remaining MDU busy cycles
   int s16      = 0;
   int s4       = 0;

   function automatic vec_t idle_v();
      vec_t v;
      v.rst = 0; v.rs = '0; v.rt = '0; v.uses_rs = 0; v.uses_rt = 0;
      v.uses_hilo = 0; v.jump = 0; v.memread = 0; v.rd = '0; v.br = 0;
      v.start = 0; v.is_div = 0;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      exp_t e;
      logic lu, busy, ms;
      @(posedge Clk);
      #1;
      Rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.uses_rs;
      id_uses_rt = v.uses_rt; id_uses_hilo = v.uses_hilo; id_jump = v.jump;
      ex_memread = v.memread; ex_rd = v.rd; ex_branch_taken = v.br;
      mdu_start = v.start; mdu_is_div = v.is_div;

      lu   = v.memread && (v.rd != 0) &&
             ((v.uses_rs && v.rs == v.rd) || (v.uses_rt && v.rt == v.rd));
      busy = !v.rst && (busy_rem > 0);
      ms   = busy && v.uses_hilo;

      if (v.rst || v.br)  e.ctl = 5'b11111;
      else if (lu || ms)  e.ctl = 5'b00011;
      else if (v.jump)    e.ctl = 5'b11110;
      else                e.ctl = 5'b11010;
      e.busy = busy;
      e.s16  = 16'(s16);
      e.s4   = 4'(s4);
      exp_q.push_back(e);

      // Advance the model to the state after the coming edge.
      if (v.rst) begin
         busy_rem = 0; s16 = 0; s4 = 0;
      end else begin
         if ((lu || ms) && !v.br) begin
            if (s16 < 65535) s16++;
            if (s4 < 15)     s4++;
         end
         if (busy_rem > 0)  busy_rem--;
         else if (v.start)  busy_rem = v.is_div ? DIV_LAT : MUL_LAT;
      end
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      vec_t v;
      Rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
      id_uses_hilo = 0; id_jump = 0; ex_memread = 0; ex_branch_taken = 0;
      mdu_start = 0; mdu_is_div = 0;

      // Reset, then idle.
      v = idle_v(); v.rst = 1;
      repeat (2) apply(v);
      apply(idle_v());

      // Load-use on rs, then on register 0 (no stall).
      v = idle_v(); v.memread = 1; v.rd = 8; v.uses_rs = 1; v.rs = 8;
      apply(v);
      apply(idle_v());
      v = idle_v(); v.memread = 1; v.rd = 0; v.uses_rs = 1; v.rs = 0;
      apply(v);
      // Load-use on rt.
      v = idle_v(); v.memread = 1; v.rd = 17; v.uses_rt = 1; v.rt = 17; v.rs = 17;
      apply(v);

      // Branch overrides load-use.
      v = idle_v(); v.memread = 1; v.rd = 8; v.uses_rs = 1; v.rs = 8; v.br = 1;
      apply(v);
      apply(idle_v());

      // MUL latency with a HI/LO reader waiting in ID.
      v = idle_v(); v.start = 1; v.is_div = 0;
      apply(v);
      v = idle_v(); v.uses_hilo = 1;
      repeat (6) apply(v);

      // DIV with a re-issue at cycle 10 and a taken branch at cycle 5.
      v = idle_v(); v.start = 1; v.is_div = 1;
      apply(v);
      for (int i = 1; i <= 34; i++) begin
         v = idle_v(); v.uses_hilo = 1;
         if (i == 5)  v.br = 1;
         if (i == 10) begin v.start = 1; v.is_div = 1; end
         apply(v);
      end

      // Reset in the middle of a DIV.
      v = idle_v(); v.start = 1; v.is_div = 1;
      apply(v);
      v = idle_v(); v.uses_hilo = 1;
      repeat (11) apply(v);
      v.rst = 1;
      apply(v);
      v.rst = 0;
      repeat (3) apply(v);

      // Hold load-use for 20 cycles: 4-bit counter saturates at 15.
      v = idle_v(); v.memread = 1; v.rd = 3; v.uses_rt = 1; v.rt = 3;
      repeat (20) apply(v);
      apply(idle_v());

      // Jump alone.
      v = idle_v(); v.jump = 1;
      apply(v);
      apply(idle_v());

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         v.rst       = ($urandom_range(0, 199) == 0);
         v.rs        = REG_W'($urandom_range(0, 3));
         v.rt        = REG_W'($urandom_range(0, 3));
         v.rd        = REG_W'($urandom_range(0, 3));
         v.uses_rs   = $urandom_range(0, 1) == 1;
         v.uses_rt   = $urandom_range(0, 1) == 1;
         v.uses_hilo = $urandom_range(0, 1) == 1;
         v.jump      = ($urandom_range(0, 7) == 0);
         v.memread   = $urandom_range(0, 1) == 1;
         v.br        = ($urandom_range(0, 7) == 0);
         v.start     = ($urandom_range(0, 15) == 0);
         v.is_div    = $urandom_range(0, 1) == 1;
         apply(v);
      end

      // Let the monitor drain the scoreboard, bounded.
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge Clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected responses left unchecked, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
